div_seq: RTL and testbench
==========================

DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 The block SHALL have one parameter: DW, default 32, operand/result width; only 32 is supported.
REQ-002 Port clk SHALL be: input, 1 bit, the single clock; all state changes on the rising edge.
REQ-003 Port resetn SHALL be: input, 1 bit, asynchronous active-low reset.
REQ-004 Port div_start SHALL be: input, 1 bit, request from the EX stage; held high while div_ready is low.
REQ-005 Port div_signed SHALL be: input, 1 bit, 1 for signed DIV and 0 for DIVU; sampled at acceptance.
REQ-006 Port opr1 SHALL be: input, 32 bits, dividend; sampled at acceptance.
REQ-007 Port opr2 SHALL be: input, 32 bits, divisor; sampled at acceptance.
REQ-008 Port flush SHALL be: input, 1 bit, pipeline flush or exception cancel.
REQ-009 Port div_ready SHALL be: output, 1 bit, one-cycle pulse when the result is valid.
REQ-010 Port quot SHALL be: output, 32 bits, quotient, written to LO.
REQ-011 Port rem SHALL be: output, 32 bits, remainder, written to HI.
REQ-012 Port busy SHALL be: output, 1 bit, high in the BUSY and DONE states.

Function
REQ-013 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-014 Acceptance:
- In IDLE, with div_start=1 and flush=0, the block SHALL latch opr1, opr2 and div_signed, load the counter with 0, and go to BUSY.
REQ-015 Signed preparation: when div_signed=1, the block SHALL operate on the magnitudes |opr1| and |opr2|.
REQ-016 It SHALL record the quotient sign as opr1[31]^opr2[31] and the remainder sign as opr1[31].
REQ-017 BUSY iteration:
- Each cycle SHALL perform one restoring shift-subtract step on a 64-bit partial remainder: one quotient bit per cycle, MSB first.
- The counter SHALL increment each cycle.
- After the step with counter=31, the block SHALL go to DONE.
REQ-018 DONE:
- div_ready=1 for exactly one cycle.
- quot/rem SHALL carry the sign-corrected results.
- Next state SHALL be IDLE unconditionally.
REQ-019 Latency: if acceptance occurs at edge N, div_ready SHALL be high in the cycle following edge N+33, i.e. 33 cycles after acceptance.
REQ-020 quot and rem SHALL hold their last DONE value until the next DONE; they SHALL not change during BUSY.
REQ-021 Unsigned results SHALL satisfy opr1 = quot*opr2 + rem with rem < opr2.
REQ-022 Signed results SHALL truncate toward zero.
REQ-023 Signed 0x80000000 / 0xFFFFFFFF SHALL give quot=0x80000000 and rem=0.
REQ-024 Flush:
- flush=1 in any state SHALL force IDLE on the next edge.
- div_ready SHALL stay low, and quot/rem SHALL keep their previous values.
- When flush and div_start are asserted together, flush SHALL win.
REQ-025 div_start while BUSY or DONE SHALL be ignored. A new operation SHALL be accepted no earlier than the cycle after DONE.
REQ-026 Divide by zero (macro absent): the block SHALL run the full 32 iterations.
- Unsigned result: quot=0xFFFFFFFF, rem=opr1.
- Signed result: the magnitude result with sign correction applied.
- No exception SHALL be raised.

Reset
REQ-027 While resetn=0, the state SHALL be IDLE, the counter 0, and div_ready=0, busy=0, quot=0, rem=0, asynchronously.
REQ-028 Reset asserted mid-operation SHALL abort it with no div_ready pulse.
REQ-029 The first operation after resetn rises SHALL behave identically to any other.

Configuration
REQ-030 When the macro DIV_ZERO_FAST_EN is defined and the latched divisor is 0, the block SHALL go from IDLE directly to DONE.
- div_ready SHALL be high 1 cycle after acceptance.
- quot SHALL be 0xFFFFFFFF and rem SHALL be opr1, for signed and unsigned alike.
REQ-031 When DIV_ZERO_FAST_EN is undefined, divide by zero SHALL follow REQ-026 with the normal 33-cycle latency.

Verification
REQ-032 Unsigned 100/7: opr1=100, opr2=7, div_signed=0 -> div_ready 33 cycles after acceptance, quot=14, rem=2, busy low the cycle after.
REQ-033 Signed -7/2: opr1=0xFFFFFFF9, opr2=2, div_signed=1 -> quot=0xFFFFFFFD, rem=0xFFFFFFFF.
REQ-034 Signed overflow: opr1=0x80000000, opr2=0xFFFFFFFF, div_signed=1 -> quot=0x80000000, rem=0.
REQ-035 Flush then restart: flush pulsed 10 cycles after acceptance -> IDLE, no div_ready, quot/rem unchanged; then start 9/3 unsigned -> quot=3, rem=0 after 33 cycles.
REQ-036 Divide by zero: opr1=0x1234, opr2=0, unsigned.
- With DIV_ZERO_FAST_EN: div_ready 1 cycle after acceptance, quot=0xFFFFFFFF, rem=0x1234.
- Without: the same values after 33 cycles.
REQ-037 Reset mid-operation: resetn pulled low 5 cycles after acceptance -> all outputs 0 immediately; after release, 100/7 completes correctly.

Source files
------------

// File: rtl/div_seq.sv
// Sequential 32-cycle restoring divider for DIV/DIVU, results to LO (quot) and HI (rem).
// Define DIV_ZERO_FAST_EN to finish a divide by zero one cycle after acceptance.
module div_seq #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          div_start,
    input  logic          div_signed,
    input  logic [DW-1:0] opr1,
    input  logic [DW-1:0] opr2,
    input  logic          flush,
    output logic          div_ready,
    output logic [DW-1:0] quot,
    output logic [DW-1:0] rem,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [4:0]      cnt;
    logic [63:0]     pr;
    logic [DW-1:0]   dvs;
    logic            q_neg;
    logic            r_neg;
    logic            accept;
    logic            zero_fast;
    logic [DW-1:0]   mag1;
    logic [DW-1:0]   mag2;
    logic [64:0]     sh;
    logic [32:0]     diff;
    logic [63:0]     pr_step;
    logic [DW-1:0]   q_fix;
    logic [DW-1:0]   r_fix;

    assign accept = (state == IDLE) && div_start && !flush;
    assign busy   = (state != IDLE);

`ifdef DIV_ZERO_FAST_EN
    assign zero_fast = (opr2 == '0);
`else
    assign zero_fast = 1'b0;
`endif

    assign mag1 = (div_signed && opr1[DW-1]) ? -opr1 : opr1;
    assign mag2 = (div_signed && opr2[DW-1]) ? -opr2 : opr2;

    // One restoring step: the shifted-out MSB is kept so 2R+1 cannot overflow.
    assign sh      = {pr, 1'b0};
    assign diff    = sh[64:32] - {1'b0, dvs};
    assign pr_step = diff[32] ? sh[63:0] : {diff[31:0], sh[31:1], 1'b1};

    assign q_fix = q_neg ? -pr[31:0] : pr[31:0];
    assign r_fix = r_neg ? -pr[63:32] : pr[63:32];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (flush) begin
            next_state = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (div_start) begin
                        next_state = zero_fast ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == 5'd31) begin
                        next_state = DONE;
                    end
                end
                DONE:    next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // The fast zero path preloads the final {rem, quot} with signs cleared.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt   <= '0;
            pr    <= '0;
            dvs   <= '0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
        end else if (accept) begin
            cnt   <= '0;
            pr    <= zero_fast ? {opr1, {DW{1'b1}}} : {{DW{1'b0}}, mag1};
            dvs   <= mag2;
            q_neg <= div_signed && (opr1[DW-1] ^ opr2[DW-1]) && !zero_fast;
            r_neg <= div_signed && opr1[DW-1] && !zero_fast;
        end else if (state == BUSY) begin
            cnt <= cnt + 5'd1;
            pr  <= pr_step;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_ready <= 1'b0;
            quot      <= '0;
            rem       <= '0;
        end else begin
            div_ready <= (state == DONE) && !flush;
            if ((state == DONE) && !flush) begin
                quot <= q_fix;
                rem  <= r_fix;
            end
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Randomised bench for div_seq against a cycle-level arithmetic model.
// Honours DIV_ZERO_FAST_EN for divide-by-zero latency and results.
module tb_div_seq;

    logic        clk;
    logic        resetn;
    logic        div_start;
    logic        div_signed;
    logic [31:0] opr1;
    logic [31:0] opr2;
    logic        flush;
    logic        div_ready;
    logic [31:0] quot;
    logic [31:0] rem;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    div_seq #(.DW(32)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .div_start  (div_start),
        .div_signed (div_signed),
        .opr1       (opr1),
        .opr2       (opr2),
        .flush      (flush),
        .div_ready  (div_ready),
        .quot       (quot),
        .rem        (rem),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    // Expected {quot, rem} straight from the arithmetic definition.
    function automatic logic [63:0] model(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic s);
        int sa;
        int sb;
        int q;
        int r;
`ifdef DIV_ZERO_FAST_EN
        if (b == 0) return {32'hFFFFFFFF, a};
`endif
        if (!s) begin
            if (b == 0) return {32'hFFFFFFFF, a};
            return {a / b, a % b};
        end
        sa = int'(a);
        sb = int'(b);
        if (b == 0) return {(sa < 0) ? 32'd1 : 32'hFFFFFFFF, a};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF)
            return {32'h80000000, 32'd0};
        q = sa / sb;
        r = sa % sb;
        return {q, r};
    endfunction

    function automatic int lat(input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
        if (b == 0) return 1;
`endif
        return 33;
    endfunction

    // Monitor: per-edge model update, then compare every cycle.
    int          m_left = 0;
    logic        m_rdy  = 1'b0;
    logic [31:0] h_q    = '0;
    logic [31:0] h_r    = '0;
    logic [31:0] p_q    = '0;
    logic [31:0] p_r    = '0;

    initial forever begin
        @(posedge clk);
        if (!resetn) begin
            m_left = 0;
            m_rdy  = 1'b0;
            h_q    = '0;
            h_r    = '0;
        end else begin
            m_rdy = 1'b0;
            if (flush) begin
                m_left = 0;
            end else if (m_left == 0) begin
                if (div_start) begin
                    {p_q, p_r} = model(opr1, opr2, div_signed);
                    m_left = lat(opr2);
                end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_rdy = 1'b1;
                    h_q   = p_q;
                    h_r   = p_r;
                end
            end
        end
        #1;
        chk("mon_ready", {31'd0, div_ready}, {31'd0, m_rdy});
        chk("mon_busy", {31'd0, busy}, {31'd0, m_left > 0});
        chk("mon_quot", quot, h_q);
        chk("mon_rem", rem, h_r);
    end

    task automatic wait_idle();
        for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    endtask

    task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                            input logic s);
        wait_idle();
        @(negedge clk);
        opr1       = a;
        opr2       = b;
        div_signed = s;
        div_start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        div_start = 1'b0;
    endtask

    task automatic wait_ready(input string name, output int n);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #2;
            if (div_ready) begin
                n = i;
                break;
            end
        end
        if (n == 0) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic run_op(input string name, input logic [31:0] a,
                          input logic [31:0] b, input logic s,
                          input int exp_lat, input logic [31:0] eq,
                          input logic [31:0] er);
        int n;
        start_op(a, b, s);
        wait_ready(name, n);
        chk({name, "_lat"}, n, exp_lat);
        chk({name, "_quot"}, quot, eq);
        chk({name, "_rem"}, rem, er);
        @(posedge clk);
        #2;
        chk({name, "_busy_after"}, {31'd0, busy}, 32'd0);
        chk({name, "_ready_drop"}, {31'd0, div_ready}, 32'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom % 6)
            0:       return 32'd0;
            1:       return 32'h80000000;
            2:       return 32'hFFFFFFFF;
            3:       return $urandom % 16;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int zl;
        resetn     = 1'b0;
        div_start  = 1'b0;
        div_signed = 1'b0;
        opr1       = '0;
        opr2       = '0;
        flush      = 1'b0;
`ifdef DIV_ZERO_FAST_EN
        zl = 1;
`else
        zl = 33;
`endif
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_quot", quot, 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        run_op("u100_7", 32'd100, 32'd7, 1'b0, 33, 32'd14, 32'd2);
        run_op("s_m7_2", 32'hFFFFFFF9, 32'd2, 1'b1, 33, 32'hFFFFFFFD,
               32'hFFFFFFFF);
        run_op("s_ovf", 32'h80000000, 32'hFFFFFFFF, 1'b1, 33, 32'h80000000,
               32'd0);

        start_op(32'd100, 32'd7, 1'b0);
        repeat (9) @(negedge clk);
        flush     = 1'b1;
        div_start = 1'b1;
        @(negedge clk);
        flush     = 1'b0;
        div_start = 1'b0;
        repeat (40) @(negedge clk);
        chk("flush_quot", quot, 32'h80000000);
        chk("flush_rem", rem, 32'd0);
        run_op("u9_3", 32'd9, 32'd3, 1'b0, 33, 32'd3, 32'd0);

        run_op("dz_u", 32'h1234, 32'd0, 1'b0, zl, 32'hFFFFFFFF, 32'h1234);

        start_op(32'd50, 32'd5, 1'b0);
        repeat (4) @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("arst_ready", {31'd0, div_ready}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_quot", quot, 32'd0);
        chk("arst_rem", rem, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        run_op("post_rst", 32'd100, 32'd7, 1'b0, 33, 32'd14, 32'd2);

        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            div_start  = ($urandom % 4) != 0;
            flush      = ($urandom % 60) == 0;
            div_signed = $urandom;
            opr1       = pick();
            opr2       = pick();
        end
        @(negedge clk);
        div_start = 1'b0;
        flush     = 1'b0;
        repeat (40) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
